// File: rtl/bm_if_result_collector_if.sv
// Result-sample and drain-port bundle for bm_if_result_collector.
// master: upstream producer plus drain consumer; slave: the collector.
interface bm_if_result_collector_if #(
   parameter int unsigned BITS = 2
);
   logic            in_valid;
   logic [BITS-1:0] res0;
   logic [BITS-1:0] res2;
   logic            res1;
   logic [2*BITS:0] out_data;
   logic            out_valid;
   logic            out_ready;

   modport master (
      output in_valid, res0, res2, res1, out_ready,
      input  out_data, out_valid
   );

   modport slave (
      input  in_valid, res0, res2, res1, out_ready,
      output out_data, out_valid
   );
endinterface

// File: rtl/bm_if_result_collector.sv
// Captures a programmed number of packed result words into a small FIFO,
// folds each accepted word into an 8-bit MISR and counts accepts/drops.
module bm_if_result_collector #(
   parameter int unsigned BITS  = 2,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start_i,
   input  logic [CNT_W-1:0]    capture_len_i,
   bm_if_result_collector_if.slave io,
   output logic [7:0]          signature_o,
   output logic [CNT_W-1:0]    accept_cnt_o,
   output logic [CNT_W-1:0]    drop_cnt_o,
   output logic                busy_o,
   output logic                done_o
);

   localparam int unsigned WordW = 2 * BITS + 1;
   localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW  = PtrW + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StCapture, StDrain, StDone} state_e;

   state_e                 state_q, state_d;
   logic [WordW-1:0]       mem_q [DEPTH];
   logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]        count_q;
   logic [CNT_W-1:0]       len_q, len_d;
   logic [CNT_W-1:0]       accept_cnt_q, accept_cnt_d;
   logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;
   logic [7:0]             sig_q, sig_d;
   logic [WordW-1:0]       word;
   logic [7:0]             word_ext;
   logic                   push, pop;

   assign word = {io.res2, io.res0, io.res1};

   always_comb begin
      word_ext = '0;
      word_ext[WordW-1:0] = word;
   end

   // A full FIFO still accepts when the head leaves in the same cycle.
   assign pop  = (count_q != '0) && io.out_ready;
   assign push = (state_q == StCapture) && io.in_valid && ((count_q < FullCnt) || pop);

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      accept_cnt_d = accept_cnt_q;
      drop_cnt_d   = drop_cnt_q;
      sig_d        = sig_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               len_d        = capture_len_i;
               accept_cnt_d = '0;
               drop_cnt_d   = '0;
               sig_d        = '0;
               state_d      = (capture_len_i != '0) ? StCapture : StDrain;
            end
         end
         StCapture: begin
            if (push) begin
               accept_cnt_d = accept_cnt_q + CNT_W'(1);
               sig_d = {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3]} ^ word_ext;
               if (accept_cnt_d == len_q) begin
                  state_d = StDrain;
               end
            end else if (io.in_valid && (drop_cnt_q != '1)) begin
               drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
         end
         StDrain: begin
            if (count_q == '0) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         len_q        <= '0;
         accept_cnt_q <= '0;
         drop_cnt_q   <= '0;
         sig_q        <= '0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         accept_cnt_q <= accept_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         sig_q        <= sig_d;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= word;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign io.out_data  = mem_q[rd_ptr_q];
   assign io.out_valid = (count_q != '0);
   assign signature_o  = sig_q;
   assign accept_cnt_o = accept_cnt_q;
   assign drop_cnt_o   = drop_cnt_q;
   assign busy_o       = (state_q == StCapture) || (state_q == StDrain);
   assign done_o       = (state_q == StDone);

endmodule

// File: tb/tb_bm_if_result_collector.sv
// Bench for bm_if_result_collector: vector table, scoreboarded drain order,
// and hand sequences for full/drop, zero length and asynchronous abort.
module tb_bm_if_result_collector;

   logic       clock;
   logic       reset_n;
   logic       start;
   logic [7:0] capture_len;
   logic [7:0] signature;
   logic [7:0] accept_cnt;
   logic [7:0] drop_cnt;
   logic       busy;
   logic       done;

   int tests;
   int fails;

   logic [4:0] exp_q[$];
   logic [4:0] got_q[$];

   bm_if_result_collector_if #(.BITS(2)) ifc ();

   bm_if_result_collector #(.BITS(2), .DEPTH(4), .CNT_W(8)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .start_i       (start),
      .capture_len_i (capture_len),
      .io            (ifc),
      .signature_o   (signature),
      .accept_cnt_o  (accept_cnt),
      .drop_cnt_o    (drop_cnt),
      .busy_o        (busy),
      .done_o        (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Record every word leaving the FIFO; inputs are stable at the falling edge.
   always @(negedge clock) begin
      if (reset_n && ifc.out_valid && ifc.out_ready) got_q.push_back(ifc.out_data);
   end

   typedef struct {
      logic       st;
      logic [7:0] len;
      logic       iv;
      logic [4:0] w;
      logic       rdy;
      logic       acc_exp;
      logic       ov;
      logic [4:0] od;
      logic       busy;
      logic       done;
      logic [7:0] acc;
      logic [7:0] drop;
      logic [7:0] sig;
   } vec_t;

   function automatic vec_t mk(logic st, logic [7:0] len, logic iv, logic [4:0] w, logic rdy,
                               logic acc_exp, logic ov, logic [4:0] od, logic b, logic d,
                               logic [7:0] acc, logic [7:0] drop, logic [7:0] sig);
      vec_t v;
      v.st = st; v.len = len; v.iv = iv; v.w = w; v.rdy = rdy; v.acc_exp = acc_exp;
      v.ov = ov; v.od = od; v.busy = b; v.done = d; v.acc = acc; v.drop = drop; v.sig = sig;
      return v;
   endfunction

   function automatic logic [7:0] misr(logic [7:0] s, logic [4:0] w);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {3'b000, w};
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(logic st, logic [7:0] len, logic iv, logic [4:0] w, logic rdy);
      start       = st;
      capture_len = len;
      ifc.in_valid = iv;
      ifc.res2    = w[4:3];
      ifc.res0    = w[2:1];
      ifc.res1    = w[0];
      ifc.out_ready = rdy;
   endtask

   task automatic check_drain(string name);
      chk({name, " pop count"}, got_q.size(), exp_q.size());
      while (exp_q.size() != 0 && got_q.size() != 0) begin
         chk({name, " pop word"}, got_q.pop_front(), exp_q.pop_front());
      end
      exp_q.delete();
      got_q.delete();
   endtask

   vec_t vecs[14];
   logic [7:0] sig_model;
   logic [4:0] seq_words[6];
   int         waited;

   initial begin
      tests = 0;
      fails = 0;
      reset_n = 1'b0;
      drive(1'b0, 8'd0, 1'b0, 5'd0, 1'b0);

      //      st len iv w     rdy ae ov od    bsy dn acc drop sig
      vecs[0]  = mk(1, 2, 0, 5'h00, 1, 0, 0, 5'h00, 1, 0, 0, 0, 8'h00);
      vecs[1]  = mk(0, 0, 1, 5'h01, 1, 1, 1, 5'h01, 1, 0, 1, 0, 8'h01);
      vecs[2]  = mk(0, 0, 1, 5'h00, 1, 1, 1, 5'h00, 1, 0, 2, 0, 8'h02);
      vecs[3]  = mk(0, 0, 0, 5'h00, 1, 0, 0, 5'h00, 1, 0, 2, 0, 8'h02);
      vecs[4]  = mk(0, 0, 0, 5'h00, 1, 0, 0, 5'h00, 0, 1, 2, 0, 8'h02);
      vecs[5]  = mk(1, 0, 1, 5'h1f, 1, 0, 0, 5'h00, 1, 0, 0, 0, 8'h00);
      vecs[6]  = mk(0, 0, 1, 5'h1f, 1, 0, 0, 5'h00, 0, 1, 0, 0, 8'h00);
      vecs[7]  = mk(0, 0, 1, 5'h1f, 1, 0, 0, 5'h00, 0, 1, 0, 0, 8'h00);
      vecs[8]  = mk(1, 3, 0, 5'h00, 1, 0, 0, 5'h00, 1, 0, 0, 0, 8'h00);
      vecs[9]  = mk(1, 1, 1, 5'h0a, 1, 1, 1, 5'h0a, 1, 0, 1, 0, 8'h0a);
      vecs[10] = mk(1, 1, 1, 5'h15, 1, 1, 1, 5'h15, 1, 0, 2, 0, 8'h00);
      vecs[11] = mk(0, 0, 1, 5'h03, 1, 1, 1, 5'h03, 1, 0, 3, 0, 8'h03);
      vecs[12] = mk(1, 5, 1, 5'h1f, 1, 0, 0, 5'h00, 1, 0, 3, 0, 8'h03);
      vecs[13] = mk(0, 0, 0, 5'h00, 1, 0, 0, 5'h00, 0, 1, 3, 0, 8'h03);

      #12;
      chk("reset out_valid", ifc.out_valid, 0);
      chk("reset out_data", ifc.out_data, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset signature", signature, 0);
      chk("reset accept_cnt", accept_cnt, 0);
      chk("reset drop_cnt", drop_cnt, 0);
      @(negedge clock);
      reset_n = 1'b1;
      tick();

      foreach (vecs[i]) begin
         drive(vecs[i].st, vecs[i].len, vecs[i].iv, vecs[i].w, vecs[i].rdy);
         if (vecs[i].acc_exp) exp_q.push_back(vecs[i].w);
         tick();
         chk($sformatf("vec%0d out_valid", i), ifc.out_valid, vecs[i].ov);
         if (vecs[i].ov) chk($sformatf("vec%0d out_data", i), ifc.out_data, vecs[i].od);
         chk($sformatf("vec%0d busy", i), busy, vecs[i].busy);
         chk($sformatf("vec%0d done", i), done, vecs[i].done);
         chk($sformatf("vec%0d accept_cnt", i), accept_cnt, vecs[i].acc);
         chk($sformatf("vec%0d drop_cnt", i), drop_cnt, vecs[i].drop);
         chk($sformatf("vec%0d signature", i), signature, vecs[i].sig);
      end
      check_drain("table");

      // Full/drop, then a push that coincides with a pop while full.
      drive(1'b1, 8'd6, 1'b0, 5'd0, 1'b0);
      tick();
      for (int k = 1; k <= 6; k++) begin
         drive(1'b0, 8'd0, 1'b1, 5'(k), 1'b0);
         if (k <= 4) exp_q.push_back(5'(k));
         tick();
      end
      chk("full accept_cnt", accept_cnt, 4);
      chk("full drop_cnt", drop_cnt, 2);
      chk("full busy", busy, 1);
      chk("full out_valid", ifc.out_valid, 1);
      chk("full out_data", ifc.out_data, 5'h01);
      drive(1'b0, 8'd0, 1'b1, 5'h07, 1'b1);
      exp_q.push_back(5'h07);
      tick();
      chk("fullpop accept_cnt", accept_cnt, 5);
      chk("fullpop out_data", ifc.out_data, 5'h02);
      chk("fullpop busy", busy, 1);
      drive(1'b0, 8'd0, 1'b1, 5'h08, 1'b1);
      exp_q.push_back(5'h08);
      tick();
      chk("fullpop last accept_cnt", accept_cnt, 6);
      drive(1'b0, 8'd0, 1'b0, 5'h00, 1'b1);
      waited = 0;
      while (!done && waited < 20) begin
         tick();
         waited++;
      end
      chk("drain reaches done", done, 1);
      seq_words = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h07, 5'h08};
      sig_model = 8'h00;
      foreach (seq_words[i]) sig_model = misr(sig_model, seq_words[i]);
      chk("full signature", signature, sig_model);
      chk("full drop_cnt held", drop_cnt, 2);
      check_drain("full");

      // Abort during DRAIN with three words buffered.
      drive(1'b1, 8'd3, 1'b0, 5'd0, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 8'd0, 1'b1, 5'(k + 9), 1'b0);
         tick();
      end
      drive(1'b0, 8'd0, 1'b0, 5'd0, 1'b0);
      chk("abort pre busy", busy, 1);
      chk("abort pre out_valid", ifc.out_valid, 1);
      chk("abort pre accept_cnt", accept_cnt, 3);
      #3;
      reset_n = 1'b0;
      #1;
      chk("abort out_valid", ifc.out_valid, 0);
      chk("abort out_data", ifc.out_data, 0);
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort signature", signature, 0);
      chk("abort accept_cnt", accept_cnt, 0);
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      chk("post-abort busy", busy, 0);
      chk("post-abort done", done, 0);
      chk("post-abort out_valid", ifc.out_valid, 0);
      drive(1'b1, 8'd1, 1'b0, 5'd0, 1'b1);
      tick();
      chk("idle start busy", busy, 1);
      drive(1'b0, 8'd0, 1'b0, 5'd0, 1'b1);
      check_drain("abort");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bm_if_result_collector.md
Name: bm_if_result_collector

Overview:
- Downstream stage of the if-collapse microbenchmark top.
- Consumes its registered results (2-bit out0, 2-bit out2, 1-bit out1), packs each sample into one word and buffers it in a small FIFO with a valid/ready drain port.
- Compresses every accepted word into an 8-bit MISR signature.
- A start-driven FSM captures a programmed number of samples, then drains. Accepted and dropped samples are counted for synthesis-equivalence checking.

Parameters:
BITS, 2, operand/result width of the upstream stage
DEPTH, 4, FIFO entries (power of 2, >=2)
CNT_W, 8, width of capture_len and the counters

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a capture run (honoured in IDLE/DONE only)
capture_len  in  CNT_W  number of words to accept; sampled on accepted start
in_valid  in  1  upstream result sample valid this cycle
res0  in  BITS  upstream out0
res2  in  BITS  upstream out2
res1  in  1  upstream out1
out_data  out  2*BITS+1  FIFO head word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head this cycle
signature  out  8  MISR over accepted words
accept_cnt  out  CNT_W  words accepted this run
drop_cnt  out  CNT_W  words dropped (FIFO full) this run, saturating at all-ones
busy  out  1  high in CAPTURE or DRAIN
done  out  1  high in DONE

Behaviour:
- Reset: clock and reset_n as already decided; reset_n is asynchronous and active-low, clock is rising-edge. On reset:
  - FSM goes to IDLE and FIFO is emptied, with storage cleared to 0.
  - out_data=0, out_valid=0, signature=0x00, accept_cnt=0, drop_cnt=0, busy=0, done=0.
  - Reset mid-run aborts the run immediately and discards buffered words.
- Word packing: word = {res2, res0, res1} (MSB to LSB), width 2*BITS+1 = 5.
- FSM states IDLE, CAPTURE, DRAIN, DONE:
  - IDLE + start, capture_len!=0 -> CAPTURE. Load the length and clear signature, accept_cnt and drop_cnt.
  - IDLE + start, capture_len==0 -> DRAIN, with the same clears.
  - CAPTURE -> DRAIN in the cycle after the accept that brings accept_cnt to the loaded length.
  - DRAIN -> DONE when the FIFO is empty. A DRAIN entered with an empty FIFO lasts 1 cycle.
  - DONE + start behaves exactly as IDLE + start. Otherwise DONE holds, with done=1.
  - start in CAPTURE or DRAIN is ignored.
- Push: only in CAPTURE, with in_valid=1.
  - The word is accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the word is dropped and drop_cnt increments, saturating.
  - in_valid outside CAPTURE is ignored: no push, no count.
  - Dropped words do not count toward capture_len.
- Pop: occurs when out_valid && out_ready, in any state.
- Latency and ordering: an accepted word is visible on out_data/out_valid one cycle after acceptance. There is no fall-through. Order is FIFO.
- Simultaneous push and pop: count is unchanged. Pointers wrap modulo DEPTH.
- MISR, updated on each accepted word w (zero-extended to 8 bits):
  - fb = sig[7]^sig[5]^sig[4]^sig[3]
  - sig <= {sig[6:0], fb} ^ w
- accept_cnt: increments by 1 per accepted word. It never exceeds the loaded length.
- Counters and signature hold their values through DRAIN and DONE until the next accepted start.

Test Plan:
- Reset: assert reset_n=0 mid-clock -> all outputs 0 immediately (async); busy=0, done=0, out_valid=0.
- Basic run:
  - Stimulus: start, capture_len=2; push words {0,0,1} then {0,0,0}; out_ready=1.
  - Required: out_data 0x01 then 0x00, each one cycle after its push.
  - Required: signature=0x02, accept_cnt=2, drop_cnt=0; done=1 after the FIFO empties.
- Full/drop:
  - Stimulus: capture_len=6, out_ready=0, 6 consecutive valid words 0x01..0x06.
  - Required: accept_cnt=4, drop_cnt=2, state stays CAPTURE, out_data=0x01.
- Full with pop:
  - Stimulus: continue the previous case with out_ready=1 plus valid word 0x07 in the same cycle.
  - Required: 0x07 accepted, count stays 4, drain order 0x02,0x03,0x04,0x07.
- Zero length: start with capture_len=0 -> busy=1 for 1 cycle (DRAIN), done=1 on the next cycle; in_valid ignored.
- Restart and abort:
  - start while busy -> ignored.
  - start in DONE -> counters and signature cleared to 0.
  - reset_n low during DRAIN with 3 words buffered -> out_valid=0 at once; after release, FSM is IDLE.
